// File: rtl/seven_seg_to_bcd.sv
// Glitch-filtered 7-segment to BCD decoder with a single-entry valid/ready output hold register.
// Optional macro HEX_DECODE_EN adds A..F patterns as legal data.
module seven_seg_to_bcd #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    output logic [3:0] out_bcd,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    state_t     state_q;
    logic [6:0] seg_q;
    logic [6:0] seg_d;
    logic [3:0] cnt_q;
    logic [3:0] out_bcd_q;
    logic       out_err_q;
    logic       out_valid_q;
    logic       overflow_q;

    logic [3:0] dec_bcd;
    logic       dec_err;
    logic       dec_blank;
    logic       accept;
    logic       beat;
    logic       xfer;

    assign seg_d = SEG_ACTIVE_LOW ? ~seg_in : seg_in;

    // Decode the candidate that is being accepted (the registered pattern).
    always_comb begin
        dec_bcd   = 4'hF;
        dec_err   = 1'b1;
        dec_blank = 1'b0;
        case (seg_q)
            7'h3F: begin dec_bcd = 4'd0; dec_err = 1'b0; end
            7'h06: begin dec_bcd = 4'd1; dec_err = 1'b0; end
            7'h5B: begin dec_bcd = 4'd2; dec_err = 1'b0; end
            7'h4F: begin dec_bcd = 4'd3; dec_err = 1'b0; end
            7'h66: begin dec_bcd = 4'd4; dec_err = 1'b0; end
            7'h6D: begin dec_bcd = 4'd5; dec_err = 1'b0; end
            7'h7D: begin dec_bcd = 4'd6; dec_err = 1'b0; end
            7'h07: begin dec_bcd = 4'd7; dec_err = 1'b0; end
            7'h7F: begin dec_bcd = 4'd8; dec_err = 1'b0; end
            7'h67: begin dec_bcd = 4'd9; dec_err = 1'b0; end
`ifdef HEX_DECODE_EN
            7'h77: begin dec_bcd = 4'hA; dec_err = 1'b0; end
            7'h7C: begin dec_bcd = 4'hB; dec_err = 1'b0; end
            7'h39: begin dec_bcd = 4'hC; dec_err = 1'b0; end
            7'h5E: begin dec_bcd = 4'hD; dec_err = 1'b0; end
            7'h79: begin dec_bcd = 4'hE; dec_err = 1'b0; end
            7'h71: begin dec_bcd = 4'hF; dec_err = 1'b0; end
`endif
            7'h00: begin dec_bcd = 4'h0; dec_err = 1'b0; dec_blank = 1'b1; end
            default: begin dec_bcd = 4'hF; dec_err = 1'b1; end
        endcase
    end

    assign accept = (state_q == COUNT) && (seg_d == seg_q) && (cnt_q >= CNT_LAST);
    assign beat   = accept && !dec_blank;
    assign xfer   = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_q       <= 7'h00;
            cnt_q       <= 4'd0;
            state_q     <= IDLE;
            out_bcd_q   <= 4'd0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            if (seg_d != seg_q) begin
                cnt_q   <= 4'd0;
                state_q <= COUNT;
            end else if (state_q == COUNT) begin
                if (cnt_q < CNT_LAST) begin
                    cnt_q <= cnt_q + 4'd1;
                end else begin
                    state_q <= LOCKED;
                end
            end

            // A freeing transfer on the accept edge lets the new beat load instead of overflowing.
            if (beat) begin
                if (!out_valid_q || out_ready) begin
                    out_bcd_q   <= dec_bcd;
                    out_err_q   <= dec_err;
                    out_valid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (xfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_bcd   = out_bcd_q;
    assign out_err   = out_err_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seven_seg_to_bcd.sv
// Randomized and directed bench for seven_seg_to_bcd against a run-length reference model.
module tb_seven_seg_to_bcd;

    localparam int S = 4;

    logic       clk;
    logic       reset;
    logic [6:0] seg_in;
    logic [3:0] out_bcd;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;

    int vectors;
    int miscompares;

    // Reference model state: a pattern is accepted once it has been seen on S+1 consecutive edges.
    logic [6:0] m_prev;
    int         m_run;
    logic       m_valid;
    logic [3:0] m_bcd;
    logic       m_err;
    logic       m_ovf;

    logic [4:0] got_q[$];
    logic [4:0] exp_q[$];
    logic [4:0] m_xfer_q[$];

    logic [6:0] dig_tab [10];
    logic [6:0] hex_tab [6];

    seven_seg_to_bcd #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_in    (seg_in),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        logic [4:0] r;
        r = {1'b1, 4'hF};
        for (int i = 0; i < 10; i++) if (p == dig_tab[i]) r = {1'b0, 4'(i)};
`ifdef HEX_DECODE_EN
        for (int i = 0; i < 6; i++) if (p == hex_tab[i]) r = {1'b0, 4'(10 + i)};
`endif
        return r;
    endfunction

    task automatic step(input logic [6:0] seg, input logic rdy, input logic rst_n);
        logic       pre_v;
        logic [4:0] pre_d;
        logic       xf;
        logic       bt;
        logic [4:0] d;
        @(negedge clk);
        seg_in    = seg;
        out_ready = rdy;
        reset     = rst_n;
        pre_v     = out_valid;
        pre_d     = {out_err, out_bcd};
        @(posedge clk);
        if (rst_n && pre_v && rdy) got_q.push_back(pre_d);
        if (!rst_n) begin
            m_prev = 7'h00; m_run = 0; m_valid = 1'b0;
            m_bcd = 4'd0; m_err = 1'b0; m_ovf = 1'b0;
        end else begin
            xf = m_valid && rdy;
            if (xf) m_xfer_q.push_back({m_err, m_bcd});
            bt = 1'b0;
            d  = 5'd0;
            if (seg != m_prev) begin
                m_prev = seg;
                m_run  = 1;
            end else if (m_run > 0) begin
                m_run++;
                if (m_run == S + 1 && seg != 7'h00) begin
                    bt = 1'b1;
                    d  = ref_decode(seg);
                end
            end
            if (bt) begin
                if (!m_valid || rdy) begin
                    m_valid = 1'b1;
                    {m_err, m_bcd} = d;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (xf) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(7'h00, 1'b1, 1'b0);
            vectors++;
            if ({out_valid, out_err, out_bcd, overflow} !== 7'd0) begin
                miscompares++;
                $display("FAIL reset: got v=%b e=%b bcd=%h ovf=%b want all 0", out_valid, out_err, out_bcd, overflow);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(7'h00, 1'b1, 1'b1);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle: got v=%b want 0", out_valid);
            end
        end
        got_q.delete();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 10; i++) begin
            step(7'h5B, 1'b1, 1'b1);
            vectors++;
            if (out_valid !== (i == 4)) begin
                miscompares++;
                $display("FAIL basic_timing[%0d]: got v=%b want %b", i, out_valid, (i == 4));
            end
            if (i == 4) begin
                vectors++;
                if ({out_err, out_bcd} !== 5'h02) begin
                    miscompares++;
                    $display("FAIL basic_data: got err=%b bcd=%h want err=0 bcd=2", out_err, out_bcd);
                end
            end
        end
        vectors++;
        if (got_q.size() != 1) begin
            miscompares++;
            $display("FAIL basic_count: got %0d beats want 1", got_q.size());
        end
        got_q.delete();
    endtask

    task automatic test_glitch();
        logic [6:0] pat [11] = '{7'h06, 7'h06, 7'h4F, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};
        exp_q = '{5'h01};
        for (int i = 0; i < 11; i++) begin
            step(pat[i], 1'b1, 1'b1);
            vectors++;
            if (out_valid !== m_valid || overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL glitch_flags[%0d]: got v=%b ovf=%b want v=%b ovf=%b", i, out_valid, overflow, m_valid, m_ovf);
            end
        end
        vectors++;
        if (got_q != exp_q) begin
            miscompares++;
            $display("FAIL glitch_beats: got %p want %p", got_q, exp_q);
        end
        got_q.delete();
    endtask

    task automatic test_sweep();
        exp_q.delete();
        for (int d = 0; d < 10; d++) begin
            exp_q.push_back(5'(d));
            for (int i = 0; i < 9; i++) begin
                step((i < 6) ? dig_tab[d] : 7'h00, 1'b1, 1'b1);
                vectors++;
                if (out_valid !== m_valid || (m_valid && {out_err, out_bcd} !== {m_err, m_bcd})) begin
                    miscompares++;
                    $display("FAIL sweep[%0d.%0d]: got v=%b e=%b bcd=%h want v=%b e=%b bcd=%h",
                             d, i, out_valid, out_err, out_bcd, m_valid, m_err, m_bcd);
                end
            end
        end
        vectors++;
        if (got_q != exp_q) begin
            miscompares++;
            $display("FAIL sweep_beats: got %p want %p", got_q, exp_q);
        end
        got_q.delete();
    endtask

    task automatic test_hex();
`ifdef HEX_DECODE_EN
        exp_q = '{5'h0B};
`else
        exp_q = '{5'h1F};
`endif
        for (int i = 0; i < 8; i++) step((i < 6) ? 7'h7C : 7'h00, 1'b1, 1'b1);
        vectors++;
        if (got_q != exp_q) begin
            miscompares++;
            $display("FAIL hex_7c: got %p want %p", got_q, exp_q);
        end
        got_q.delete();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 12; i++) step((i < 6) ? 7'h7F : 7'h6D, 1'b0, 1'b1);
        vectors++;
        if ({out_valid, overflow, out_err, out_bcd} !== 7'b11_0_1000) begin
            miscompares++;
            $display("FAIL ovf_hold: got v=%b ovf=%b e=%b bcd=%h want v=1 ovf=1 e=0 bcd=8", out_valid, overflow, out_err, out_bcd);
        end
        for (int i = 0; i < 3; i++) step(7'h6D, 1'b1, 1'b1);
        exp_q = '{5'h08};
        vectors++;
        if (got_q != exp_q || out_valid !== 1'b0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drain: got %p v=%b ovf=%b want %p v=0 ovf=1", got_q, out_valid, overflow, exp_q);
        end
        got_q.delete();
        step(7'h00, 1'b1, 1'b0);
        step(7'h00, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(7'h66, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(7'h07, 1'b0, 1'b1);
        step(7'h07, 1'b1, 1'b1);
        vectors++;
        if ({out_valid, overflow, out_err, out_bcd} !== 7'b10_0_0111) begin
            miscompares++;
            $display("FAIL same_edge: got v=%b ovf=%b e=%b bcd=%h want v=1 ovf=0 e=0 bcd=7", out_valid, overflow, out_err, out_bcd);
        end
        step(7'h07, 1'b1, 1'b1);
        exp_q = '{5'h04, 5'h07};
        vectors++;
        if (got_q != exp_q || out_valid !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL same_edge_beats: got %p v=%b ovf=%b want %p v=0 ovf=0", got_q, out_valid, overflow, exp_q);
        end
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        step(7'h4F, 1'b1, 1'b1);
        step(7'h4F, 1'b1, 1'b1);
        step(7'h4F, 1'b1, 1'b0);
        vectors++;
        if ({out_valid, out_err, out_bcd, overflow} !== 7'd0) begin
            miscompares++;
            $display("FAIL rst_count: got v=%b e=%b bcd=%h ovf=%b want all 0", out_valid, out_err, out_bcd, overflow);
        end
        for (int i = 0; i < 6; i++) step(7'h4F, 1'b0, 1'b1);
        step(7'h4F, 1'b0, 1'b0);
        vectors++;
        if ({out_valid, out_err, out_bcd, overflow} !== 7'd0) begin
            miscompares++;
            $display("FAIL rst_held: got v=%b e=%b bcd=%h ovf=%b want all 0", out_valid, out_err, out_bcd, overflow);
        end
        for (int i = 0; i < 7; i++) begin
            step(7'h4F, 1'b1, 1'b1);
            vectors++;
            if (out_valid !== (i == 4)) begin
                miscompares++;
                $display("FAIL rst_restab[%0d]: got v=%b want %b", i, out_valid, (i == 4));
            end
        end
        exp_q = '{5'h03};
        vectors++;
        if (got_q != exp_q) begin
            miscompares++;
            $display("FAIL rst_beats: got %p want %p", got_q, exp_q);
        end
        got_q.delete();
    endtask

    task automatic test_random();
        logic [6:0] p;
        int         hold;
        int         r;
        step(7'h00, 1'b1, 1'b0);
        got_q.delete();
        m_xfer_q.delete();
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       p = dig_tab[$urandom_range(0, 9)];
            else if (r == 5) p = 7'h00;
            else if (r == 6) p = hex_tab[$urandom_range(0, 5)];
            else             p = 7'($urandom_range(0, 127));
            hold = $urandom_range(1, 7);
            for (int i = 0; i < hold; i++) begin
                step(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 60) != 0));
                vectors++;
                if (out_valid !== m_valid || overflow !== m_ovf ||
                    (m_valid && {out_err, out_bcd} !== {m_err, m_bcd})) begin
                    miscompares++;
                    $display("FAIL random[%0d.%0d] seg=%h: got v=%b ovf=%b e=%b bcd=%h want v=%b ovf=%b e=%b bcd=%h",
                             n, i, p, out_valid, overflow, out_err, out_bcd, m_valid, m_ovf, m_err, m_bcd);
                end
            end
        end
        vectors++;
        if (got_q != m_xfer_q) begin
            miscompares++;
            $display("FAIL random_beats: got %0d beats want %0d", got_q.size(), m_xfer_q.size());
        end
        got_q.delete();
    endtask

    initial begin
        dig_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};
        hex_tab = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        seg_in      = 7'h00;
        out_ready   = 1'b1;
        m_prev = 7'h00; m_run = 0; m_valid = 1'b0; m_bcd = 4'd0; m_err = 1'b0; m_ovf = 1'b0;

        test_reset();
        test_basic();
        test_glitch();
        test_sweep();
        test_hex();
        test_overflow();
        test_reset_mid();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_to_bcd.md
Name: seven_seg_to_bcd

Overview:
Decodes a sampled 7-segment drive pattern back to a BCD digit. It is the inverse of the BCD-to-7-segment encoder and is used for display loopback checking and for reading external segment buses. The input is glitch-filtered by a stability counter. Each newly stable pattern produces one decoded beat on a valid/ready output port with a single-entry hold register.

Parameters:
STABLE_CYCLES, 4, consecutive sampling edges a pattern must stay unchanged before it is accepted (legal range 1..15).
SEG_ACTIVE_LOW, 0, 1 = seg_in is inverted at the input register before any comparison or decode.

Ports:
clk  input  1  single clock; all logic on its rising edge
reset  input  1  synchronous, active-low reset
seg_in  input  7  segment pattern; bit0=A, bit1=B, bit2=C, bit3=D, bit4=E, bit5=F, bit6=G
out_bcd  output  4  decoded digit
out_err  output  1  beat carries a non-digit pattern
out_valid  output  1  beat available
out_ready  input  1  consumer accepts the beat
overflow  output  1  sticky flag: a beat was dropped

Behaviour:
- Reset (reset==0 at a rising edge): seg_q=0, cnt=0, state=IDLE, out_bcd=0, out_err=0, out_valid=0, overflow=0.
  - Reset mid-filter or mid-handshake discards everything, including any held beat.
- Sampling: seg_q <= (SEG_ACTIVE_LOW ? ~seg_in : seg_in) every edge. Compare against the same conditioned value.
- States:
  - IDLE: no candidate.
  - COUNT: filtering a candidate.
  - LOCKED: candidate already emitted.
- Any state, conditioned seg_in != seg_q at an edge: cnt<=0, state<=COUNT.
- COUNT, input equals seg_q:
  - If cnt<STABLE_CYCLES-1: cnt<=cnt+1.
  - Otherwise: accept and go to LOCKED.
  - Timing: a pattern first sampled at edge k is accepted at edge k+STABLE_CYCLES, and out_valid is visible after that edge.
- LOCKED, input unchanged: hold. The same pattern is never re-emitted.
- Decode at acceptance:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x67→9; out_err=0.
  - 0x00 (blank): no beat, no error; the state still goes to LOCKED.
  - Any other pattern: beat with out_bcd=4'hF, out_err=1.
- Output handshake (one hold register):
  - A transfer occurs on an edge with out_valid&&out_ready. out_valid then drops unless a new beat loads on the same edge.
  - Accept with out_valid==0, or with a transfer on the same edge: load the beat, out_valid<=1.
  - Accept with out_valid==1 and out_ready==0: the new beat is dropped, the held beat is unchanged, and overflow<=1.
  - overflow clears only on reset.
- out_bcd and out_err are stable while out_valid==1 and out_ready==0.
- Changes to out_ready while out_valid==0 have no effect.

Optional Feature:
HEX_DECODE_EN
- Defined: patterns 0x77→A, 0x7C→B, 0x39→C, 0x5E→D, 0x79→E, 0x71→F decode with out_err=0.
- Undefined: these six patterns are treated as invalid (out_bcd=F, out_err=1).
- With the macro defined, out_bcd=F can also be legal data; consumers must use out_err to tell the two apart.

Test Plan:
1. Reset held low 5 edges, out_ready=1, then seg_in=0x5B first sampled at edge 0 → out_valid=1 after edge 4, out_bcd=2, out_err=0. Pulse lasts exactly one cycle and does not repeat while 0x5B is held.
2. Glitch: seg_in=0x06 for 2 edges, 0x4F for 1 edge, then 0x06 steady (STABLE_CYCLES=4) → the 0x4F candidate is never emitted; exactly one beat is emitted, out_bcd=1.
3. Sweep all ten digit codes, each held 6 edges with 0x00 gaps between them → beats 0..9 in order, out_err=0; the gaps produce no beats.
4. seg_in=0x7C with the macro undefined → out_bcd=F, out_err=1. With HEX_DECODE_EN defined → out_bcd=B, out_err=0.
5. out_ready=0, seg_in 0x7F then 0x6D (each held 6 edges) → held beat stays 8 and overflow=1. Raise out_ready: one transfer of 8, then out_valid=0. An accept on the same edge as a transfer loads the new beat without setting overflow.
6. Drive reset low during COUNT and while a beat is held → all outputs return to 0. The held beat is lost; the pattern must restabilize before any beat is emitted.
